// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter for the kv10 ALU path: logical/arithmetic shifts and
// rotates on a WIDTH-bit word. Bit 0 in kv10 numbering (the sign) is bit WIDTH-1
// here, so a "left" shift moves data towards the MSB. Elastic valid/ready
// pipeline with PIPE_DEPTH register stages and a sticky overflow flag.
module barrel_shift_pipe #(
    parameter int unsigned WIDTH      = 36,
    parameter int unsigned SHIFT_BITS = 9,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SHIFT_BITS-1:0] in_shift,
    input  logic                  in_arith,
    input  logic                  in_rotate,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_ovf,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  ovf_sticky,
    input  logic                  clr_ovf
);

    localparam int unsigned         STEPS    = SHIFT_BITS;
    localparam logic [WIDTH-2:0]    LOW_ONES = '1;

    // Rotates are normalised to a left rotate by an amount below WIDTH.
    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_ASL = 3'd1,
        OP_LSR = 3'd2,
        OP_ASR = 3'd3,
        OP_ROL = 3'd4
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0]      data;
        logic [SHIFT_BITS-1:0] amt;
        op_e                   op;
        logic                  ovf;
        logic [TAG_W-1:0]      tag;
    } stage_t;

    // Apply the log-shifter steps lo..hi-1 (step k shifts by 2**k when amt[k] is set).
    function automatic stage_t apply_steps(input stage_t p, input int lo, input int hi);
        stage_t              q;
        logic [WIDTH-2:0]    low;
        logic [2*WIDTH-1:0]  dbl;
        int unsigned         sh;
        q = p;
        for (int k = 0; k < int'(STEPS); k++) begin
            if (k >= lo && k < hi && q.amt[k]) begin
                sh = 32'd1 << k;
                case (q.op)
                    OP_LSL: q.data = q.data << sh;
                    OP_ASL: begin
                        low                = q.data[WIDTH-2:0];
                        q.data[WIDTH-2:0]  = low << sh;
                    end
                    OP_LSR: q.data = q.data >> sh;
                    OP_ASR: q.data = $signed(q.data) >>> sh;
                    OP_ROL: begin
                        dbl    = {q.data, q.data} << sh;
                        q.data = dbl[2*WIDTH-1:WIDTH];
                    end
                    default: q.data = q.data;
                endcase
            end
        end
        return q;
    endfunction

    logic                        w_neg;
    logic [SHIFT_BITS-1:0]       w_mag;
    int unsigned                 w_rot_mod;
    stage_t                      w_prep;
    logic [PIPE_DEPTH:0]         w_load;
    logic [PIPE_DEPTH-1:0]       w_up_valid;
    stage_t [PIPE_DEPTH-1:0]     w_stage_in;
    logic                        w_unused_ctrl;

    logic [PIPE_DEPTH-1:0]       r_valid;
    stage_t [PIPE_DEPTH-1:0]     r_pay;
    logic                        r_ovf_sticky;

    // Decode the signed count into an op and unsigned amount; overflow of a
    // left arithmetic shift is judged on the original operand bits.
    always_comb begin
        w_neg     = in_shift[SHIFT_BITS-1];
        w_mag     = w_neg ? (~in_shift + SHIFT_BITS'(1)) : in_shift;
        w_rot_mod = 32'(w_mag) % WIDTH;
        w_prep      = '0;
        w_prep.data = in_data;
        w_prep.tag  = in_tag;
        if (in_rotate) begin
            w_prep.op  = OP_ROL;
            w_prep.amt = (w_neg && w_rot_mod != 0) ? SHIFT_BITS'(WIDTH - w_rot_mod)
                                                   : SHIFT_BITS'(w_rot_mod);
        end else begin
            w_prep.op  = w_neg ? (in_arith ? OP_ASR : OP_LSR) : (in_arith ? OP_ASL : OP_LSL);
            w_prep.amt = w_mag;
            w_prep.ovf = !w_neg && in_arith &&
                         (((in_data[WIDTH-2:0] ^ {(WIDTH-1){in_data[WIDTH-1]}})
                           & ~(LOW_ONES >> w_mag)) != '0);
        end
    end

    // Stage k may load when empty or when its content moves on this cycle.
    always_comb begin
        w_load             = '0;
        w_load[PIPE_DEPTH] = out_ready;
        for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
            w_load[k] = !r_valid[k] || w_load[k+1];
        end
    end

    assign in_ready = reset_n && !flush && w_load[0];

    // Route each stage's upstream payload and valid.
    always_comb begin
        w_stage_in    = '0;
        w_up_valid    = '0;
        w_stage_in[0] = w_prep;
        w_up_valid[0] = in_valid && in_ready;
        for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
            w_stage_in[k] = r_pay[k-1];
            w_up_valid[k] = r_valid[k-1];
        end
    end

    // Pipeline registers; payload only captured when a real op moves in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_pay   <= '0;
        end else begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_valid[k] <= w_up_valid[k];
                end
                if (w_load[k] && w_up_valid[k]) begin
                    r_pay[k] <= apply_steps(w_stage_in[k],
                                            int'((32'(k) * STEPS) / PIPE_DEPTH),
                                            int'((32'(k + 1) * STEPS) / PIPE_DEPTH));
                end
            end
        end
    end

    // Sticky overflow: a handed-off overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_ovf) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign out_valid     = r_valid[PIPE_DEPTH-1];
    assign out_data      = r_pay[PIPE_DEPTH-1].data;
    assign out_ovf       = r_pay[PIPE_DEPTH-1].ovf;
    assign out_tag       = r_pay[PIPE_DEPTH-1].tag;
    assign ovf_sticky    = r_ovf_sticky;
    assign w_unused_ctrl = ^{r_pay[PIPE_DEPTH-1].amt, r_pay[PIPE_DEPTH-1].op};

endmodule
